uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter FRE_CLK, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter UART_BPS, default 115200, line baud rate.
REQ-003 Derived constant CNT = FRE_CLK/UART_BPS (integer divide), clocks per bit; 868 at defaults.
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 i_uart_rx  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-007 o_data  output  8  last correctly received byte.
REQ-008 o_valid  output  1  one-cycle pulse, o_data newly valid.
REQ-009 o_frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 o_uart_busy  output  1  high while a frame is being received.

Function
REQ-011 i_uart_rx SHALL pass through a two-flop synchronizer; all logic SHALL use only the synchronized value rx_s.
REQ-012 Bit counter width SHALL be the minimum that holds CNT; the phase counter SHALL count 0..CNT-1 and then wrap.
REQ-013 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-014 IDLE SHALL go to START on a 1->0 transition of rx_s (registered previous value high, current value low), with the phase counter cleared.
REQ-015 START SHALL sample rx_s when the phase counter reaches CNT/2-1: low goes to DATA with the counter cleared; high (false start) returns to IDLE with no output pulse.
REQ-016 DATA SHALL sample rx_s each time the phase counter reaches CNT-1, eight samples in total, shifting LSB first into a shift register; the bit index SHALL run 0..7.
REQ-017 After the eighth data sample, the FSM SHALL enter STOP.
REQ-018 STOP SHALL sample rx_s when the phase counter reaches CNT-1.
REQ-019 A high stop sample SHALL load o_data from the shift register and pulse o_valid on the next cycle.
REQ-020 A low stop sample SHALL leave o_data unchanged and pulse o_frame_err on the next cycle.
REQ-021 After the stop sample, the FSM SHALL return to IDLE in both cases, i.e. mid-stop-bit, so that a following start edge is accepted immediately.
REQ-022 If the stop bit was low, a new start SHALL require rx_s to return high and then fall again; a held-low line SHALL NOT retrigger.
REQ-023 o_valid and o_frame_err SHALL be mutually exclusive and never longer than one cycle.
REQ-024 o_uart_busy SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-025 Latency: o_valid SHALL rise at most CNT/2 + 9*CNT + 4 clocks after the line's start-bit falling edge, including synchronizer delay.
REQ-026 Falling edges on rx_s outside IDLE SHALL be ignored; sampling SHALL be driven solely by the phase counter.

Reset
REQ-027 On rst high, regardless of clock, the block SHALL force: FSM IDLE, counters 0, shift register 0, o_data 8'h00, o_valid 0, o_frame_err 0, o_uart_busy 0.
REQ-028 On rst high, both synchronizer flops and the previous-sample register SHALL be set to 1 (idle line), so release SHALL NOT fake a start edge.
REQ-029 Reset mid-frame SHALL discard the partial byte with no pulse; reception SHALL resume at the next genuine falling edge after release.

Verification
REQ-030 Frame 0xA5 at 115200 baud, 8680 ns bit time, 10 ns clock -> single o_valid pulse, o_data=8'hA5, o_frame_err never high, o_uart_busy low after the pulse.
REQ-031 Frames 0x00 then 0xFF back-to-back, stop bit 1 bit wide, no idle gap -> two o_valid pulses with o_data 8'h00 then 8'hFF.
REQ-032 Low glitch of 200 clocks on an idle line -> no o_valid, no o_frame_err; o_uart_busy pulses high for about 434 clocks, then returns to IDLE.
REQ-033 Frame 0x3C with stop bit driven low -> o_frame_err one-cycle pulse; o_data keeps its previous value; a following frame 0x5A after the line goes high -> o_valid with 8'h5A.
REQ-034 rst asserted asynchronously during data bit 4 of frame 0x81 -> outputs immediately at reset values; no pulse for 0x81; next frame 0x42 -> o_data=8'h42.
REQ-035 Sender baud offset +2% and -2%, frame 0x96 -> o_data=8'h96 correctly in both cases.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, mid-bit sampling driven by a clock-divided phase counter.
module uart_rx #(
  parameter int FRE_CLK  = 100_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_uart_busy
);
  localparam int CNT = FRE_CLK / UART_BPS;
  localparam int CW = $clog2(CNT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CNT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CNT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic sync1_q, rx_s_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  // Synchronizer and edge history reset to idle-high so release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= i_uart_rx;
      rx_s_q  <= sync1_q;
      prev_q  <= rx_s_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == FULL_M1) ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (prev_q && !rx_s_q) state_d = START;
      end
      START: if (cnt_q == HALF_M1) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: if (cnt_q == FULL_M1) begin
        shift_d = {rx_s_q, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (cnt_q == FULL_M1) begin
        // Leave mid-stop-bit so a back-to-back start edge is caught immediately.
        state_d = IDLE;
        valid_d = rx_s_q;
        ferr_d  = !rx_s_q;
        data_d  = rx_s_q ? shift_q : data_q;
      end
      default: state_d = IDLE;
    endcase
  end
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_uart_busy = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frame vectors plus hand-written corner sequences for uart_rx.
module tb_uart_rx;
  localparam int CNT = 868;
  localparam int LAT_MAX = CNT / 2 + 9 * CNT + 4;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [7:0] o_data;
  logic o_valid, o_frame_err, o_uart_busy;
  int tests = 0, fails = 0;
  int cyc = 0, valid_cnt = 0, ferr_cnt = 0, busy_cnt = 0, viol = 0;
  int start_cyc = 0, valid_cyc = 0;
  logic prev_v = 1'b0, prev_f = 1'b0;
  logic [7:0] rx_q[$];
  uart_rx dut (
    .clk(clk), .rst(rst), .i_uart_rx(rx),
    .o_data(o_data), .o_valid(o_valid), .o_frame_err(o_frame_err), .o_uart_busy(o_uart_busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (o_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
      rx_q.push_back(o_data);
    end
    if (o_frame_err) ferr_cnt++;
    if (o_uart_busy) busy_cnt++;
    if ((o_valid && prev_v) || (o_frame_err && prev_f) || (o_valid && o_frame_err)) viol++;
    prev_v = o_valid;
    prev_f = o_frame_err;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk);
    @(negedge clk);
    rx = 1'b0;
    start_cyc = cyc;
    idle(bclk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(bclk);
    end
    rx = stop;
    idle(bclk);
    rx = 1'b1;
  endtask
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         bclk;
    logic       exp_v;
    logic       exp_f;
    logic [7:0] exp_d;
  } vec_t;
  vec_t vecs[5];
  int v0, f0;
  initial begin
    vecs[0] = '{8'hA5, 1'b1, 868, 1'b1, 1'b0, 8'hA5};
    vecs[1] = '{8'h96, 1'b1, 885, 1'b1, 1'b0, 8'h96};
    vecs[2] = '{8'h96, 1'b1, 851, 1'b1, 1'b0, 8'h96};
    vecs[3] = '{8'h3C, 1'b0, 868, 1'b0, 1'b1, 8'h96};
    vecs[4] = '{8'h5A, 1'b1, 868, 1'b1, 1'b0, 8'h5A};
    #23 rst = 1'b0;
    idle(20);
    chk("reset_data", o_data, 8'h00);
    chk("reset_valid", o_valid, 1'b0);
    chk("reset_ferr", o_frame_err, 1'b0);
    chk("reset_busy", o_uart_busy, 1'b0);
    for (int k = 0; k < 5; k++) begin
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(vecs[k].data, vecs[k].stop, vecs[k].bclk);
      idle(2 * CNT);
      chk($sformatf("vec%0d_valid_cnt", k), valid_cnt - v0, vecs[k].exp_v);
      chk($sformatf("vec%0d_ferr_cnt", k), ferr_cnt - f0, vecs[k].exp_f);
      chk($sformatf("vec%0d_data", k), o_data, vecs[k].exp_d);
      chk($sformatf("vec%0d_busy", k), o_uart_busy, 1'b0);
      if (vecs[k].exp_v) chk($sformatf("vec%0d_latency_ok", k), (valid_cyc - start_cyc) <= LAT_MAX, 1'b1);
    end
    rx_q.delete();
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1, CNT);
    send_frame(8'hFF, 1'b1, CNT);
    idle(2 * CNT);
    chk("b2b_valid_cnt", valid_cnt - v0, 2);
    chk("b2b_first", rx_q[0], 8'h00);
    chk("b2b_second", rx_q[1], 8'hFF);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    busy_cnt = 0;
    rx = 1'b0;
    idle(200);
    rx = 1'b1;
    idle(1000);
    chk("glitch_valid", valid_cnt - v0, 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    chk("glitch_busy_len_ok", (busy_cnt >= 430) && (busy_cnt <= 440), 1'b1);
    chk("glitch_idle", o_uart_busy, 1'b0);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    fork
      send_frame(8'h81, 1'b1, CNT);
      begin
        idle(5 * CNT + CNT / 2);
        chk("midframe_busy", o_uart_busy, 1'b1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_data", o_data, 8'h00);
        chk("async_rst_busy", o_uart_busy, 1'b0);
        chk("async_rst_valid", o_valid, 1'b0);
      end
    join
    @(negedge clk) rst = 1'b0;
    idle(2 * CNT);
    chk("rst_no_valid", valid_cnt - v0, 0);
    chk("rst_no_ferr", ferr_cnt - f0, 0);
    send_frame(8'h42, 1'b1, CNT);
    idle(2 * CNT);
    chk("after_rst_valid", valid_cnt - v0, 1);
    chk("after_rst_data", o_data, 8'h42);
    chk("pulse_rules", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
